id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 93 +++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and flush/hazard bubble insertion.
// Load-use detection is compiled in only when HAZARD_DETECT_EN is defined; otherwise only flush creates bubbles.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_RegDs,
    input  logic          id_Branch,
    input  logic          id_MRead,
    input  logic          id_MtoR,
    input  logic          id_MWrite,
    input  logic          id_ALUsrc,
    input  logic          id_Urw,
    input  logic [2:0]    id_AOp,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    output logic          ex_RegDs,
    output logic          ex_Branch,
    output logic          ex_MRead,
    output logic          ex_MtoR,
    output logic          ex_MWrite,
    output logic          ex_ALUsrc,
    output logic          ex_Urw,
    output logic [2:0]    ex_AOp,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic          ex_valid,
    output logic          stall,
    output logic [15:0]   bubble_cnt
);

    localparam int PW = 10 + 4*DW + 3*RW;

    logic [PW-1:0] stage_d, stage_q;
    logic          valid_d, valid_q;
    logic [15:0]   cnt_d, cnt_q;
    logic          hazard;
    logic          bubble;

`ifdef HAZARD_DETECT_EN
    // A bubble in EX clears ex_MRead, so a load-use stall can never last longer than one cycle.
    assign hazard = ex_MRead && valid_q && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
`else
    assign hazard = 1'b0;
`endif

    assign stall  = hazard && !flush;
    assign bubble = hazard || flush;

    always_comb begin
        stage_d = '0;
        if (!bubble) begin
            stage_d = {id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw,
                       id_AOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd};
        end
        valid_d = !bubble;
        cnt_d   = cnt_q;
        if (bubble && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {ex_RegDs, ex_Branch, ex_MRead, ex_MtoR, ex_MWrite, ex_ALUsrc, ex_Urw,
            ex_AOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} = stage_q;
    assign ex_valid   = valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, random stimulus against a reference model,
// asynchronous reset and bubble counter saturation. Follows HAZARD_DETECT_EN like the design.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    // ctl = {RegDs, Branch, MRead, MtoR, MWrite, ALUsrc, Urw}
    typedef struct packed {
        logic [6:0]    ctl;
        logic [2:0]    aop;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic        e_mread;
        logic [2:0]  e_aop;
        logic [31:0] e_rd1;
        logic [15:0] e_cnt;
    } vec_t;

    logic          clk, rst, flush;
    logic          id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw;
    logic [2:0]    id_AOp;
    logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          ex_RegDs, ex_Branch, ex_MRead, ex_MtoR, ex_MWrite, ex_ALUsrc, ex_Urw;
    logic [2:0]    ex_AOp;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_valid, stall;
    logic [15:0]   bubble_cnt;

    int     n_vec = 0;
    int     n_err = 0;
    instr_t m_ex;
    bit     m_valid;
    int     m_cnt;
    vec_t   vt[10];

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_RegDs(id_RegDs), .id_Branch(id_Branch), .id_MRead(id_MRead), .id_MtoR(id_MtoR),
        .id_MWrite(id_MWrite), .id_ALUsrc(id_ALUsrc), .id_Urw(id_Urw), .id_AOp(id_AOp),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_RegDs(ex_RegDs), .ex_Branch(ex_Branch), .ex_MRead(ex_MRead), .ex_MtoR(ex_MtoR),
        .ex_MWrite(ex_MWrite), .ex_ALUsrc(ex_ALUsrc), .ex_Urw(ex_Urw), .ex_AOp(ex_AOp),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic instr_t ex_now();
        return {ex_RegDs, ex_Branch, ex_MRead, ex_MtoR, ex_MWrite, ex_ALUsrc, ex_Urw,
                ex_AOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd};
    endfunction

    function automatic instr_t mk(logic mr, logic [2:0] aop, logic [RW-1:0] rs, logic [RW-1:0] rt,
                                  logic [31:0] rd1);
        instr_t r;
        r.ctl = {~mr, 1'b0, mr, mr, 1'b0, mr, 1'b1};
        r.aop = aop;
        r.pc4 = 32'h1000;
        r.rd1 = rd1;
        r.rd2 = 32'h7;
        r.imm = mr ? 32'h4 : 32'h0;
        r.rs  = rs;
        r.rt  = rt;
        r.rd  = mr ? 5'd0 : 5'd3;
        return r;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t r;
        r.ctl = 7'($urandom);
        r.aop = 3'($urandom);
        r.pc4 = $urandom;
        r.rd1 = $urandom;
        r.rd2 = $urandom;
        r.imm = $urandom;
        r.rs  = 5'($urandom_range(0, 3));
        r.rt  = 5'($urandom_range(0, 3));
        r.rd  = 5'($urandom);
        return r;
    endfunction

    // Load-use rule: a valid load in EX whose nonzero destination is a source of the ID instruction.
    function automatic bit model_hazard(instr_t nxt);
        if (!HZ) return 1'b0;
        return m_valid && m_ex.ctl[4] && (m_ex.rt != 0) && (m_ex.rt == nxt.rs || m_ex.rt == nxt.rt);
    endfunction

    task automatic drive(input instr_t x, input logic f);
        {id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw} = x.ctl;
        id_AOp = x.aop; id_pc4 = x.pc4; id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm = x.imm;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
        flush = f;
    endtask

    task automatic model_reset();
        m_ex = '0;
        m_valid = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_ex"}, 160'(ex_now()), 160'(m_ex));
        chk({tag, "_valid"}, 160'(ex_valid), 160'(m_valid));
        chk({tag, "_cnt"}, 160'(bubble_cnt), 160'(m_cnt));
    endtask

    // Called one time unit after a rising edge: apply inputs and check stall mid-cycle.
    task automatic pre(input instr_t x, input logic f);
        drive(x, f);
        #3;
        chk("stall", 160'(stall), 160'(model_hazard(x) && !f));
    endtask

    task automatic post(input instr_t x, input logic f);
        bit bub;
        bub = model_hazard(x) || f;
        @(posedge clk);
        if (bub) begin
            m_ex = '0;
            m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_ex = x;
            m_valid = 1'b1;
        end
        #1;
        check_outputs("mdl");
    endtask

    task automatic step(input instr_t x, input logic f);
        pre(x, f);
        post(x, f);
    endtask

    initial begin
        instr_t x;

        vt[0] = '{mk(0, 3'b010, 1, 2, 32'h5),    0, 0, 1,   0, 3'b010, 32'h5, 16'd0};
        vt[1] = '{mk(1, 3'b000, 3, 8, 32'h100),  0, 0, 1,   1, 3'b000, 32'h100, 16'd0};
        vt[2] = '{mk(0, 3'b010, 8, 9, 32'h11),   0, HZ, !HZ, 0, HZ ? 3'b000 : 3'b010,
                  HZ ? 32'h0 : 32'h11, 16'(HZ)};
        vt[3] = '{mk(0, 3'b010, 8, 9, 32'h11),   0, 0, 1,   0, 3'b010, 32'h11, 16'(HZ)};
        vt[4] = '{mk(1, 3'b000, 0, 0, 32'h200),  0, 0, 1,   1, 3'b000, 32'h200, 16'(HZ)};
        vt[5] = '{mk(0, 3'b010, 0, 0, 32'h22),   0, 0, 1,   0, 3'b010, 32'h22, 16'(HZ)};
        vt[6] = '{mk(1, 3'b000, 0, 8, 32'h300),  0, 0, 1,   1, 3'b000, 32'h300, 16'(HZ)};
        vt[7] = '{mk(0, 3'b010, 8, 9, 32'h33),   1, 0, 0,   0, 3'b000, 32'h0, 16'(HZ) + 16'd1};
        vt[8] = '{mk(1, 3'b000, 8, 8, 32'h400),  0, 0, 1,   1, 3'b000, 32'h400, 16'(HZ) + 16'd1};
        vt[9] = '{mk(0, 3'b010, 8, 0, 32'h44),   1, 0, 0,   0, 3'b000, 32'h0, 16'(HZ) + 16'd2};

        rst = 1'b1;
        drive('0, 1'b0);
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset_stall", 160'(stall), 160'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pre(vt[i].in, vt[i].fl);
            chk($sformatf("tbl%0d_stall", i), 160'(stall), 160'(vt[i].e_stall));
            post(vt[i].in, vt[i].fl);
            chk($sformatf("tbl%0d_valid", i), 160'(ex_valid), 160'(vt[i].e_valid));
            chk($sformatf("tbl%0d_mread", i), 160'(ex_MRead), 160'(vt[i].e_mread));
            chk($sformatf("tbl%0d_aop", i), 160'(ex_AOp), 160'(vt[i].e_aop));
            chk($sformatf("tbl%0d_rd1", i), 160'(ex_rd1), 160'(vt[i].e_rd1));
            chk($sformatf("tbl%0d_cnt", i), 160'(bubble_cnt), 160'(vt[i].e_cnt));
        end

        for (int i = 0; i < 1500; i++) begin
            x = rnd_instr();
            step(x, ($urandom_range(0, 7) == 0));
        end

        // Load EX with known nonzero contents, then reset asynchronously mid-cycle.
        step(rnd_instr(), 1'b1);
        step(mk(0, 3'b010, 1, 2, 32'h5), 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_stall", 160'(stall), 160'(0));
        @(posedge clk);
        #4 rst = 1'b0;
        x = mk(1, 3'b101, 2, 6, 32'hCAFE);
        step(x, 1'b0);
        chk("first_after_rst_valid", 160'(ex_valid), 160'(1));
        chk("first_after_rst_rd1", 160'(ex_rd1), 160'(32'hCAFE));

        for (int i = 0; i < 65534; i++) begin
            step(rnd_instr(), 1'b1);
        end
        chk("cnt_before_sat", 160'(bubble_cnt), 160'(16'hFFFE));
        step(rnd_instr(), 1'b1);
        chk("cnt_sat", 160'(bubble_cnt), 160'(16'hFFFF));
        step(rnd_instr(), 1'b1);
        chk("cnt_stays_sat", 160'(bubble_cnt), 160'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
